// File: rtl/calc_pkg.sv
// Shared definitions for calculator_core: FSM state encodings, opcodes and flag bit indices.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WITH_A = 2'd1,
        ST_WITH_B = 2'd2,
        ST_RESULT = 2'd3
    } calc_state_e;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_NOT = 5;
    localparam int OP_SHL = 6;
    localparam int OP_SHR = 7;

    localparam int FLG_ERR   = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLAG_W    = 4;

endpackage

// File: rtl/calculator_core_if.sv
// Board-side bundle for calculator_core: switches and buttons in, display word, state and flags out.
interface calc_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
);
    // No valid/ready pair here: result_valid is a level that is high while the
    // result register holds a computed value, and flags_o is meaningful only then.
    logic [WIDTH+OP_W-1:0] Switchs;
    logic                  Enter;
    logic                  Clear;
    logic [1:0]            state_o;
    logic [WIDTH-1:0]      display_o;
    logic                  result_valid;
    logic [3:0]            flags_o;

    modport master (
        output Switchs, Enter, Clear,
        input  state_o, display_o, result_valid, flags_o
    );

    modport slave (
        input  Switchs, Enter, Clear,
        output state_o, display_o, result_valid, flags_o
    );
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU for calculator_core: unsigned WIDTH-bit result plus carry/borrow, signed overflow and error.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             error
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        error    = 1'b0;
        case (op)
            OP_W'(OP_ADD): begin
                result   = sum_ext[WIDTH-1:0];
                carry    = sum_ext[WIDTH];
                overflow = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            // The extra bit of the widened difference is the borrow out.
            OP_W'(OP_SUB): begin
                result   = diff_ext[WIDTH-1:0];
                carry    = diff_ext[WIDTH];
                overflow = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            OP_W'(OP_AND): result = a & b;
            OP_W'(OP_OR):  result = a | b;
            OP_W'(OP_XOR): result = a ^ b;
            OP_W'(OP_NOT): result = ~a;
            OP_W'(OP_SHL): begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[MSB];
            end
            OP_W'(OP_SHR): begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: error = 1'b1;
        endcase
    end

endmodule

// File: rtl/calculator_core.sv
// Calculator core: button synchronisers, A/B/op entry FSM and registered ALU result with flags.
// Define CALC_CHAIN_EN to make Enter in RESULT load A from the previous result.
module calculator_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic   clock,
    input  logic   reset,
    calc_if.slave  bus
);

    logic [2:0] enter_sync_q, enter_sync_d;
    logic [2:0] clear_sync_q, clear_sync_d;
    logic       enter_evt, clear_evt;

    calc_state_e       state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              rv_q, rv_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic [WIDTH-1:0]  sw_data;
    logic [OP_W-1:0]   sw_op;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry, alu_ovf, alu_err;

    assign sw_data = bus.Switchs[WIDTH-1:0];
    assign sw_op   = bus.Switchs[WIDTH+OP_W-1:WIDTH];

    // Bit 0 is the metastability catcher; the event fires on s2 high while s3 is still low.
    assign enter_sync_d = {enter_sync_q[1:0], bus.Enter};
    assign clear_sync_d = {clear_sync_q[1:0], bus.Clear};
    assign enter_evt    = enter_sync_q[1] & ~enter_sync_q[2];
    assign clear_evt    = clear_sync_q[1] & ~clear_sync_q[2];

    calc_alu #(.WIDTH(WIDTH), .OP_W(OP_W)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_ovf),
        .error    (alu_err)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        rv_d     = rv_q;
        flags_d  = flags_q;
        if (clear_evt) begin
            state_d  = ST_IDLE;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            result_d = '0;
            rv_d     = 1'b0;
            flags_d  = '0;
        end else if (enter_evt) begin
            case (state_q)
                ST_IDLE: begin
                    a_d     = sw_data;
                    state_d = ST_WITH_A;
                end
                ST_WITH_A: begin
                    b_d     = sw_data;
                    state_d = ST_WITH_B;
                end
                ST_WITH_B: begin
                    op_d    = sw_op;
                    state_d = ST_RESULT;
                end
                default: begin
`ifdef CALC_CHAIN_EN
                    a_d = result_q;
`else
                    a_d = sw_data;
`endif
                    b_d     = '0;
                    rv_d    = 1'b0;
                    state_d = ST_WITH_A;
                end
            endcase
        end else if (state_q == ST_RESULT && !rv_q) begin
            result_d           = alu_result;
            rv_d               = 1'b1;
            flags_d            = '0;
            flags_d[FLG_ERR]   = alu_err;
            flags_d[FLG_ZERO]  = (alu_result == '0) && !alu_err;
            flags_d[FLG_CARRY] = alu_carry;
            flags_d[FLG_OVF]   = alu_ovf;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_sync_q <= '0;
            clear_sync_q <= '0;
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            rv_q         <= 1'b0;
            flags_q      <= '0;
        end else begin
            enter_sync_q <= enter_sync_d;
            clear_sync_q <= clear_sync_d;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            rv_q         <= rv_d;
            flags_q      <= flags_d;
        end
    end

    always_comb begin
        bus.display_o = sw_data;
        case (state_q)
            ST_IDLE:   bus.display_o = sw_data;
            ST_WITH_A: bus.display_o = a_q;
            ST_WITH_B: bus.display_o = b_q;
            default:   bus.display_o = rv_q ? result_q : b_q;
        endcase
    end

    assign bus.state_o      = state_q;
    assign bus.result_valid = rv_q;
    assign bus.flags_o      = rv_q ? flags_q : '0;

endmodule

// File: tb/tb_calculator_core.sv
// Directed bench for calculator_core (WIDTH=8, OP_W=4) with a result scoreboard.
module tb_calculator_core;
    localparam int W  = 8;
    localparam int OW = 4;

    logic clock;
    logic reset;

    calc_if #(.WIDTH(W), .OP_W(OW)) bus ();

    calculator_core #(.WIDTH(W), .OP_W(OW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W+3:0] exp_q[$];
    logic prev_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compare {display, flags} each time a result becomes valid
    always @(negedge clock) begin
        if (!reset && bus.result_valid && !prev_rv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                check("result_flags", {20'd0, bus.display_o, bus.flags_o}, {20'd0, exp_q.pop_front()});
            end
        end
        prev_rv = bus.result_valid;
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press_enter(input logic [W+OW-1:0] sw);
        bus.Switchs = sw;
        bus.Enter   = 1'b1;
        repeat (2) step();
        bus.Enter = 1'b0;
        repeat (3) step();
    endtask

    task automatic press_clear();
        bus.Clear = 1'b1;
        repeat (2) step();
        bus.Clear = 1'b0;
        repeat (3) step();
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        logic found;
        press_clear();
        press_enter({{OW{1'b0}}, a});
        press_enter({{OW{1'b0}}, b});
        exp_q.push_back({exp_res, exp_flags});
        bus.Switchs = {op, {W{1'b0}}};
        bus.Enter   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (bus.state_o == 2'd3) found = 1'b1;
        end
        check("reach_result", {31'd0, found}, 32'd1);
        if (found) begin
            check("rv_low_first_result_cycle", {31'd0, bus.result_valid}, 32'd0);
            check("display_b_before_valid", {24'd0, bus.display_o}, {24'd0, b});
            @(negedge clock);
            check("rv_one_cycle_later", {31'd0, bus.result_valid}, 32'd1);
        end
        step();
        bus.Enter = 1'b0;
        repeat (2) step();
    endtask

    // directed vectors: {a, b, op, expected result, expected {ovf,carry,zero,err}}
    localparam int NV = 12;
    logic [W-1:0]  v_a   [NV] = '{8'h7F, 8'h05, 8'h00, 8'h12, 8'hF0, 8'hF0, 8'hAA, 8'h0F, 8'h81, 8'h81, 8'hFF, 8'h80};
    logic [W-1:0]  v_b   [NV] = '{8'h01, 8'h05, 8'h01, 8'h34, 8'h3C, 8'h0F, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    logic [OW-1:0] v_op  [NV] = '{4'h0,  4'h1,  4'h1,  4'hA,  4'h2,  4'h3,  4'h4,  4'h5,  4'h6,  4'h7,  4'h0,  4'h1};
    logic [W-1:0]  v_res [NV] = '{8'h80, 8'h00, 8'hFF, 8'h00, 8'h30, 8'hFF, 8'h00, 8'hF0, 8'h02, 8'h40, 8'h00, 8'h7F};
    logic [3:0]    v_flg [NV] = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b0000,
                                  4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0110, 4'b1000};

    initial begin
        logic [W-1:0] exp_chain_a;
        reset       = 1'b1;
        bus.Switchs = {4'h0, 8'h5A};
        bus.Enter   = 1'b0;
        bus.Clear   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_state", {30'd0, bus.state_o}, 32'd0);
        check("reset_display_live", {24'd0, bus.display_o}, 32'h5A);
        check("reset_rv", {31'd0, bus.result_valid}, 32'd0);
        check("reset_flags", {28'd0, bus.flags_o}, 32'd0);
        step();
        reset = 1'b0;
        repeat (2) step();

        for (int i = 0; i < NV; i++) begin
            run_op(v_a[i], v_b[i], v_op[i], v_res[i], v_flg[i]);
        end

        // chaining on the previous result
        run_op(8'h03, 8'h04, 4'h0, 8'h07, 4'b0000);
        press_enter({4'h0, 8'h55});
`ifdef CALC_CHAIN_EN
        exp_chain_a = 8'h07;
`else
        exp_chain_a = 8'h55;
`endif
        check("rechain_state", {30'd0, bus.state_o}, 32'd1);
        check("rechain_a", {24'd0, bus.display_o}, {24'd0, exp_chain_a});
        check("rechain_rv_cleared", {31'd0, bus.result_valid}, 32'd0);
        check("rechain_flags_gated", {28'd0, bus.flags_o}, 32'd0);

        // holding Enter: one advance, two edges after the first sample
        press_clear();
        bus.Switchs = {4'h0, 8'h11};
        bus.Enter   = 1'b1;
        repeat (3) @(negedge clock);
        check("hold_not_yet", {30'd0, bus.state_o}, 32'd0);
        @(negedge clock);
        check("hold_advance", {30'd0, bus.state_o}, 32'd1);
        repeat (16) @(negedge clock);
        check("hold_no_repeat", {30'd0, bus.state_o}, 32'd1);
        check("hold_a", {24'd0, bus.display_o}, 32'h11);
        step();
        bus.Enter = 1'b0;
        repeat (2) step();

        // Enter and Clear together in WITH_B: Clear wins
        press_enter({4'h0, 8'h22});
        check("with_b_state", {30'd0, bus.state_o}, 32'd2);
        bus.Switchs = {4'h3, 8'h66};
        bus.Enter   = 1'b1;
        bus.Clear   = 1'b1;
        repeat (2) step();
        bus.Enter = 1'b0;
        bus.Clear = 1'b0;
        repeat (3) step();
        check("both_state_idle", {30'd0, bus.state_o}, 32'd0);
        check("both_a_zero", {24'd0, dut.a_q}, 32'd0);
        check("both_b_zero", {24'd0, dut.b_q}, 32'd0);
        check("both_display_live", {24'd0, bus.display_o}, 32'h66);

        // reset with an Enter event pending in WITH_B
        press_enter({4'h0, 8'h33});
        press_enter({4'h0, 8'h44});
        check("pre_reset_with_b", {30'd0, bus.state_o}, 32'd2);
        bus.Enter = 1'b1;
        repeat (2) step();
        bus.Enter   = 1'b0;
        bus.Switchs = '0;
        reset       = 1'b1;
        #2;
        check("midreset_state", {30'd0, bus.state_o}, 32'd0);
        check("midreset_display", {24'd0, bus.display_o}, 32'd0);
        check("midreset_rv", {31'd0, bus.result_valid}, 32'd0);
        check("midreset_flags", {28'd0, bus.flags_o}, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        repeat (6) step();
        check("post_reset_no_advance", {30'd0, bus.state_o}, 32'd0);

        repeat (2) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/calculator_core.md
Name: calculator_core

Overview:
- Parametrised successor of the board-level 8-bit calculator: WIDTH-bit operands, synchronised Enter/Clear edge detection, a four-state entry FSM and a registered ALU result with flags.
- Sits between the board switches/buttons and the seven-segment/LED drivers.
- Provides a display word and flag vector that downstream decoders render unchanged.

Parameters:
- WIDTH, 8, operand/result width in bits (min 4).
- OP_W, 4, opcode width taken from the top switch bits (min 3).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Switchs  input  WIDTH+OP_W  [WIDTH-1:0] operand data, [WIDTH+OP_W-1:WIDTH] opcode.
- Enter  input  1  raw button, asynchronous to clock.
- Clear  input  1  raw button, asynchronous to clock.
- state_o  output  2  FSM state (IDLE=0, WITH_A=1, WITH_B=2, RESULT=3).
- display_o  output  WIDTH  value for seven-segment drivers.
- result_valid  output  1  result register holds a computed value.
- flags_o  output  4  {overflow, carry, zero, error}; 0 unless result_valid.

Behaviour:
- Reset (async): state IDLE; A, B, op, result, result_valid, flags = 0; sync/edge flops = 0.
- Input conditioning:
  - Enter and Clear each pass through a 3-flop chain (s1, s2, s3).
  - The event is s2 & ~s3: one cycle per press, no repeat while held.
  - Enter sampled high at edge k acts at edge k+2.
- Simultaneous Enter and Clear events: Clear wins; the Enter event is dropped.
- FSM on enter_evt:
  - IDLE: A <= Switchs data; go to WITH_A.
  - WITH_A: B <= data; go to WITH_B.
  - WITH_B: op <= opcode; go to RESULT.
  - RESULT: A <= data; B, result_valid <= 0; go to WITH_A.
- FSM on clear_evt, any state: A, B, op, result, result_valid <= 0; go to IDLE. Clear in IDLE is harmless.
- Result:
  - On the first cycle in RESULT, the result register latches the ALU output and result_valid rises.
  - result_valid is therefore 1 cycle after state_o reads RESULT.
  - The result is then held until leaving RESULT.
- ALU, WIDTH-bit unsigned results; opcode values:
  - 0 ADD: carry = carry-out; overflow = signed overflow.
  - 1 SUB (A-B): carry = borrow; overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT A.
  - 6 SHL A by 1: carry = A[MSB].
  - 7 SHR A by 1: carry = A[0].
  - Any other opcode: result 0, error = 1.
- zero = (result == 0); not set for error opcodes.
- carry and overflow are 0 for ops that do not define them.
- display_o by state:
  - IDLE: live Switchs data.
  - WITH_A: A.
  - WITH_B: B.
  - RESULT: result if result_valid, else B.
- Reset mid-operation aborts immediately; button presses in flight in the sync chain are discarded.

Optional Feature:
- CALC_CHAIN_EN.
- Defined: Enter in RESULT loads A <= result (not switches) and goes to WITH_A, so operations chain on the previous result.
- Undefined: A <= switch data as above.

Decomposition:
- Package calc_pkg holds:
  - state encodings IDLE/WITH_A/WITH_B/RESULT;
  - opcode constants OP_ADD..OP_SHR;
  - flag bit indices FLG_ERR=0, FLG_ZERO=1, FLG_CARRY=2, FLG_OVF=3.
- Sub-module calc_alu: purely combinational, parametrised by WIDTH/OP_W; produces result, carry, overflow, error.
- The core instantiates calc_alu once and owns the sync, FSM and registers.

Test Plan:
- WIDTH=8: Enter with data 0x7F, then 0x01, then op 0 -> result 0x80, flags overflow=1 carry=0 zero=0; result_valid one cycle after state_o=3.
- Op 1, A=0x05, B=0x05 -> result 0x00, zero=1, carry=0. Op 1, A=0x00, B=0x01 -> 0xFF, carry=1.
- Op 0xA, A=0x12, B=0x34 -> result 0, error=1, zero=0.
- Hold Enter high 20 cycles -> exactly one state advance, 2 edges after the first sample. Enter and Clear rising together in WITH_B -> IDLE, A=B=0.
- Assert reset mid-WITH_B with Enter in the sync chain -> all outputs 0, state IDLE, no late advance after release.
- CALC_CHAIN_EN: 3+4 ADD = 7, then Enter -> A=7 in WITH_A. Without the macro, A = switch value.
